// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU behind the calculator controller's op/busy handshake.
// Add/sub take one CALC cycle; mul is shift-add and div is restoring, WIDTH cycles each (WIDTH >= 2).
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_result;
  logic             r_div_zero;

  // shift-add multiplier: accumulator, left-shifting multiplicand, LSB-first multiplier
  logic [RW-1:0]    r_acc;
  logic [RW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;

  // restoring divider: partial remainder and dividend/quotient shift register
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;

  logic             w_op_valid;
  logic             w_busy;
  logic             w_latch;
  logic             w_step;
  logic             w_write;
  logic             w_set_dz;
  logic [RW-1:0]    w_result_next;

  logic             w_last;
  logic             w_div0;
  logic [RW-1:0]    w_sum;
  logic [RW-1:0]    w_diff_ab;
  logic [RW-1:0]    w_acc_next;
  logic [WIDTH:0]   w_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_op_valid = (op_i == OP_ADD) || (op_i == OP_SUB) ||
                      (op_i == OP_MUL) || (op_i == OP_DIV);

  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_div0    = (r_b == '0);
  assign w_sum     = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
  assign w_diff_ab = {{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b};

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // when the trial subtraction fits, the true difference is below B, so a WIDTH-bit subtract is exact
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_fits     = (w_shift >= {1'b0, r_b});
  assign w_trial    = w_shift[WIDTH-1:0] - r_b;
  assign w_rem_next = w_fits ? w_trial : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

  always_comb begin
    w_state_next  = r_state;
    w_busy        = 1'b0;
    w_latch       = 1'b0;
    w_step        = 1'b0;
    w_write       = 1'b0;
    w_set_dz      = 1'b0;
    w_result_next = '0;
    case (r_state)
      S_IDLE: begin
        w_busy = w_op_valid;
        if (w_op_valid) begin
          w_latch      = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        case (r_op)
          OP_ADD: begin
            w_write       = 1'b1;
            w_result_next = w_sum;
            w_state_next  = S_DONE;
          end
          OP_SUB: begin
            w_write       = 1'b1;
            w_result_next = w_diff_ab;
            w_state_next  = S_DONE;
          end
          OP_MUL: begin
            w_step = 1'b1;
            if (w_last) begin
              w_write       = 1'b1;
              w_result_next = w_acc_next;
              w_state_next  = S_DONE;
            end
          end
          OP_DIV: begin
            if (w_div0) begin
              w_write       = 1'b1;
              w_set_dz      = 1'b1;
              w_result_next = '1;
              w_state_next  = S_DONE;
            end else begin
              w_step = 1'b1;
              if (w_last) begin
                w_write       = 1'b1;
                w_result_next = {w_rem_next, w_quo_next};
                w_state_next  = S_DONE;
              end
            end
          end
          default: w_state_next = S_DONE;
        endcase
      end
      S_DONE: begin
        if (op_i == 4'b0000) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
    end else begin
      if (w_latch) begin
        r_op     <= op_i;
        r_a      <= a_i;
        r_b      <= b_i;
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a_i};
        r_mplier <= b_i;
        r_rem    <= '0;
        r_quo    <= a_i;
      end
      if (w_step) begin
        r_cnt    <= r_cnt + CW'(1);
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_rem    <= w_rem_next;
        r_quo    <= w_quo_next;
      end
      if (w_write) begin
        r_result <= w_result_next;
      end
      if (w_set_dz) begin
        r_div_zero <= 1'b1;
      end
    end
  end

  assign busy_o     = w_busy & ~rst;
  assign result_o   = r_result;
  assign div_zero_o = r_div_zero;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed bench for seq_alu against a cycle-countdown reference model.
module tb_seq_alu;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op_i;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic       busy_o;
  logic [7:0] result_o;
  logic       div_zero_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .busy_o     (busy_o),
    .result_o   (result_o),
    .div_zero_o (div_zero_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit onehot(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd4) || (op == 4'd2) || (op == 4'd1);
  endfunction

  function automatic logic [7:0] ref_result(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    logic [3:0] q;
    logic [3:0] r;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (op)
      4'd8: return ea + eb;
      4'd4: return ea - eb;
      4'd2: return ea * eb;
      4'd1: begin
        if (b == 4'd0) return 8'hFF;
        q = a / b;
        r = a % b;
        return {r, q};
      end
      default: return 8'h00;
    endcase
  endfunction

  // number of CALC cycles an accepted op spends computing
  function automatic int ref_latency(input logic [3:0] op, input logic [3:0] b);
    if (op == 4'd2 || (op == 4'd1 && b != 4'd0)) return W;
    return 1;
  endfunction

  // Reference model: mode 0 ready to accept, 1 computing (m_left cycles to go), 2 waiting for op release.
  int         m_mode   = 0;
  int         m_left   = 0;
  logic [7:0] m_result = 8'h00;
  logic [7:0] m_pend   = 8'h00;
  bit         m_dz     = 1'b0;
  bit         m_pend_dz = 1'b0;

  initial begin
    bit exp_busy;
    forever begin
      @(negedge clk);
      if (rst)              exp_busy = 1'b0;
      else if (m_mode == 0) exp_busy = onehot(op_i);
      else                  exp_busy = (m_mode == 1);
      check("busy", {31'b0, busy_o}, {31'b0, exp_busy});
      check("result", {24'b0, result_o}, {24'b0, m_result});
      check("div_zero", {31'b0, div_zero_o}, {31'b0, m_dz});
      if (rst) begin
        m_mode   = 0;
        m_result = 8'h00;
        m_dz     = 1'b0;
      end else begin
        case (m_mode)
          0: if (onehot(op_i)) begin
            m_pend    = ref_result(op_i, a_i, b_i);
            m_pend_dz = (op_i == 4'd1) && (b_i == 4'd0);
            m_left    = ref_latency(op_i, b_i);
            m_mode    = 1;
          end
          1: begin
            m_left--;
            if (m_left == 0) begin
              m_result = m_pend;
              m_dz     = m_dz | m_pend_dz;
              m_mode   = 2;
            end
          end
          default: if (op_i == 4'd0) m_mode = 0;
        endcase
      end
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int hold, input bit scr, input bit lit, input int lit_n, input logic [7:0] lit_res);
    int n;
    int en;
    @(posedge clk); #1;
    op_i = op;
    a_i  = a;
    b_i  = b;
    n = 0;
    @(negedge clk);
    while (busy_o === 1'b1 && n < 20) begin
      n++;
      @(posedge clk); #1;
      if (scr) begin
        op_i = 4'($urandom_range(1, 15));
        a_i  = 4'($urandom);
        b_i  = 4'($urandom);
      end
      @(negedge clk);
    end
    en = onehot(op) ? ref_latency(op, b) + 1 : 0;
    check({name, "_busy_cycles"}, n, en);
    if (onehot(op)) check({name, "_res"}, {24'b0, result_o}, {24'b0, ref_result(op, a, b)});
    if (lit) begin
      check({name, "_lit_cycles"}, n, lit_n);
      check({name, "_lit_res"}, {24'b0, result_o}, {24'b0, lit_res});
    end
    repeat (hold) begin
      @(negedge clk);
      check({name, "_hold_busy"}, {31'b0, busy_o}, 32'd0);
      if (onehot(op)) check({name, "_hold_res"}, {24'b0, result_o}, {24'b0, ref_result(op, a, b)});
    end
    @(posedge clk); #1;
    op_i = 4'd0;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rop;
    int         sel;
    rst  = 1'b1;
    op_i = 4'd0;
    a_i  = 4'd0;
    b_i  = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_result", {24'b0, result_o}, 32'd0);
    check("reset_dz", {31'b0, div_zero_o}, 32'd0);

    run_op("add_7_9",   4'b1000, 4'd7,  4'd9,  0, 1'b0, 1'b1, 2, 8'h10);
    run_op("sub_3_5",   4'b0100, 4'd3,  4'd5,  0, 1'b0, 1'b1, 2, 8'hFE);
    run_op("mul_15_15", 4'b0010, 4'd15, 4'd15, 3, 1'b0, 1'b1, 5, 8'hE1);
    run_op("add_15_15", 4'b1000, 4'd15, 4'd15, 0, 1'b0, 1'b1, 2, 8'h1E);
    run_op("div_13_4",  4'b0001, 4'd13, 4'd4,  0, 1'b0, 1'b1, 5, 8'h13);
    run_op("div_5_0",   4'b0001, 4'd5,  4'd0,  1, 1'b0, 1'b1, 2, 8'hFF);
    check("dz_set", {31'b0, div_zero_o}, 32'd1);
    run_op("mul_3_4",   4'b0010, 4'd3,  4'd4,  0, 1'b0, 1'b1, 5, 8'h0C);
    check("dz_sticky", {31'b0, div_zero_o}, 32'd1);

    // abort a mul two cycles into CALC
    @(posedge clk); #1;
    op_i = 4'b0010; a_i = 4'd6; b_i = 4'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst  = 1'b1;
    op_i = 4'd0;
    @(negedge clk);
    check("rst_busy_forced", {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort_busy", {31'b0, busy_o}, 32'd0);
    check("rst_abort_res", {24'b0, result_o}, 32'd0);
    check("rst_abort_dz", {31'b0, div_zero_o}, 32'd0);
    run_op("mul_6_7",   4'b0010, 4'd6,  4'd7,  0, 1'b0, 1'b1, 5, 8'h2A);

    // invalid codes never start an op
    @(posedge clk); #1;
    op_i = 4'b0011;
    repeat (3) begin
      @(negedge clk);
      check("invalid_busy", {31'b0, busy_o}, 32'd0);
      check("invalid_res", {24'b0, result_o}, 32'h2A);
    end
    @(posedge clk); #1;
    op_i = 4'd0;
    @(negedge clk);
    check("none_busy", {31'b0, busy_o}, 32'd0);
    run_op("sub_9_2",   4'b0100, 4'd9,  4'd2,  0, 1'b0, 1'b1, 2, 8'h07);
    run_op("mul_9_11_scr", 4'b0010, 4'd9, 4'd11, 2, 1'b1, 1'b1, 5, 8'h63);
    run_op("div_14_3_scr", 4'b0001, 4'd14, 4'd3, 1, 1'b1, 1'b1, 5, 8'h24);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4)       rop = 4'(1 << sel);
      else if (sel == 4) rop = 4'($urandom);
      else               rop = 4'd0;
      run_op("rand", rop, 4'($urandom), 4'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, 0, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
